// File: rtl/fm_demod_mc.sv
// fm_demod_mc
// Multi-channel FM discriminator. For each I/Q sample it forms conj(prev)*curr
// against that channel's previous sample, takes a fixed-point quarter-arctan of
// the product (using an internal restoring divider) and applies an output gain.
// Channels arrive time-interleaved in round-robin order, and each channel keeps
// its own sample history.
//
// Ports:
//   clk        in   1       clock
//   reset      in   1       synchronous, active-high reset
//   in_empty   in   1       I/Q input FIFOs empty
//   in_rd_en   out  1       pop one I/Q pair (first-word-fall-through data)
//   real_in    in   DATA_W  I sample
//   imag_in    in   DATA_W  Q sample
//   out_dout   out  DATA_W  demodulated sample
//   out_ch     out  CH_W    channel index of out_dout
//   out_wr_en  out  1       push to output FIFO
//   out_full   in   1       output FIFO full
module fm_demod_mc #(
    parameter int DATA_W   = 32,
    parameter int BITS     = 10,
    parameter int CHANNELS = 1,
    parameter int GAIN     = 758,
    parameter int QUAD1    = 804,
    localparam int CH_W    = $clog2((CHANNELS > 2) ? CHANNELS : 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_empty,
    output logic              in_rd_en,
    input  logic [DATA_W-1:0] real_in,
    input  logic [DATA_W-1:0] imag_in,
    output logic [DATA_W-1:0] out_dout,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_wr_en,
    input  logic              out_full
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic signed [DATA_W-1:0] K_QUAD1 = DATA_W'(QUAD1);
    localparam logic signed [DATA_W-1:0] K_QUAD3 = DATA_W'(3 * QUAD1);
    localparam logic signed [DATA_W-1:0] K_GAIN  = DATA_W'(GAIN);
    localparam logic signed [DATA_W-1:0] K_RND   = DATA_W'((2 ** BITS) - 1);
    localparam logic signed [DATA_W-1:0] K_ONE   = DATA_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_DEQU, S_SETUP, S_DIV, S_POST, S_GAIN, S_OUT
    } state_t;

    // Dequantise with truncation toward zero.
    function automatic logic signed [DATA_W-1:0] dq(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] t;
        t = v[DATA_W-1] ? v + K_RND : v;
        return t >>> BITS;
    endfunction

    function automatic logic signed [DATA_W-1:0] quant(input logic signed [DATA_W-1:0] v);
        return v <<< BITS;
    endfunction

    state_t r_state, w_next;

    logic [CH_W-1:0]          r_ch;
    logic signed [DATA_W-1:0] r_bank_i [CHANNELS];
    logic signed [DATA_W-1:0] r_bank_q [CHANNELS];
    logic signed [DATA_W-1:0] r_rc, r_ic, r_rp, r_ip;
    logic signed [DATA_W-1:0] r_p_rr, r_p_ri, r_p_ii, r_p_ir;
    logic signed [DATA_W-1:0] r_x, r_y, r_base, r_a;
    logic                     r_neg;
    logic [DATA_W-1:0]        r_quo, r_rem, r_den;
    logic [CNT_W-1:0]         r_cnt;

    logic signed [DATA_W-1:0] w_ay, w_num, w_den, w_base, w_r, w_a0;
    logic [DATA_W-1:0]        w_num_mag;
    logic [DATA_W:0]          w_rem_sh, w_diff;
    logic                     w_ge;

    // Control: pops only in IDLE, writes only in OUTPUT; both held off in reset.
    always_comb begin
        w_next    = r_state;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        case (r_state)
            S_IDLE:  if (!in_empty) begin
                         in_rd_en = 1'b1;
                         w_next   = S_MULT;
                     end
            S_MULT:  w_next = S_DEQU;
            S_DEQU:  w_next = S_SETUP;
            S_SETUP: w_next = S_DIV;
            S_DIV:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next = S_POST;
            S_POST:  w_next = S_GAIN;
            S_GAIN:  w_next = S_OUT;
            S_OUT:   if (!out_full) begin
                         out_wr_en = 1'b1;
                         w_next    = S_IDLE;
                     end
            default: w_next = S_IDLE;
        endcase
        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Arctan setup: map the angle into a quadrant-relative ratio in [-1,1].
    always_comb begin
        w_ay   = (r_y[DATA_W-1] ? -r_y : r_y) + K_ONE;
        w_num  = quant(r_x - w_ay);
        w_den  = r_x + w_ay;
        w_base = K_QUAD1;
        if (r_x[DATA_W-1]) begin
            w_num  = quant(r_x + w_ay);
            w_den  = w_ay - r_x;
            w_base = K_QUAD3;
        end
        w_num_mag = w_num[DATA_W-1] ? -w_num : w_num;
    end

    // One restoring-division step; the quotient shifts in where the dividend shifts out.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[DATA_W-1]};
        w_diff   = w_rem_sh - {1'b0, r_den};
        w_ge     = !w_diff[DATA_W];
    end

    // Denominator is always positive, so the quotient takes the numerator's sign.
    always_comb begin
        w_r  = r_neg ? -r_quo : r_quo;
        w_a0 = r_base - dq(K_QUAD1 * w_r);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch     <= '0;
            out_dout <= '0;
            out_ch   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_bank_i[k] <= '0;
                r_bank_q[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (in_rd_en) begin
                    r_rc <= real_in;
                    r_ic <= imag_in;
                    r_rp <= r_bank_i[r_ch];
                    r_ip <= r_bank_q[r_ch];
                    r_bank_i[r_ch] <= real_in;
                    r_bank_q[r_ch] <= imag_in;
                end
                S_MULT: begin
                    r_p_rr <= r_rp * r_rc;
                    r_p_ri <= r_rp * r_ic;
                    r_p_ii <= (-r_ip) * r_ic;
                    r_p_ir <= (-r_ip) * r_rc;
                end
                S_DEQU: begin
                    r_x <= dq(r_p_rr) - dq(r_p_ii);
                    r_y <= dq(r_p_ri) + dq(r_p_ir);
                end
                S_SETUP: begin
                    r_neg  <= w_num[DATA_W-1];
                    r_quo  <= w_num_mag;
                    r_rem  <= '0;
                    r_den  <= w_den;
                    r_base <= w_base;
                    r_cnt  <= '0;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                    r_quo <= {r_quo[DATA_W-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_POST: r_a <= r_y[DATA_W-1] ? -w_a0 : w_a0;
                S_GAIN: begin
                    out_dout <= dq(K_GAIN * r_a);
                    out_ch   <= r_ch;
                end
                S_OUT: if (out_wr_en) begin
                    r_ch <= (r_ch == CH_W'(CHANNELS - 1)) ? '0 : r_ch + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
